// File: rtl/l1_cache_if.sv
// CPU load/store port and block-wide L2 port of the L1 data cache.
// The cache takes the slave modport; the CPU/L2 side takes the master modport.
interface l1_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32
);
  logic [ADDR_WIDTH-1:0]            cpu_addr;
  logic [DATA_WIDTH-1:0]            cpu_wdata;
  logic                             cpu_read;
  logic                             cpu_write;
  logic [DATA_WIDTH-1:0]            cpu_rdata;
  logic                             cpu_ready;
  logic                             cpu_hit;
  logic [ADDR_WIDTH-1:0]            l2_addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out;
  logic                             l2_read;
  logic                             l2_write;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data_in;
  logic                             l2_block_valid;
  logic                             l2_ready;
  logic [15:0]                      hit_count;
  logic [15:0]                      miss_count;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
    input  l2_block_data_in, l2_block_valid, l2_ready,
    output cpu_rdata, cpu_ready, cpu_hit,
    output l2_addr, l2_data_out, l2_read, l2_write,
    output hit_count, miss_count
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write,
    output l2_block_data_in, l2_block_valid, l2_ready,
    input  cpu_rdata, cpu_ready, cpu_hit,
    input  l2_addr, l2_data_out, l2_read, l2_write,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache.
// Single-word CPU loads/stores; whole-block fills from L2 and merged-block stores to L2.
module l1_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 128,
  parameter int BLOCK_SIZE = 32
) (
  input logic       clk,
  input logic       rst,
  l1_cache_if.slave bus
);
  localparam int LINES  = CACHE_SIZE / BLOCK_SIZE;
  localparam int OFFSET = $clog2(BLOCK_SIZE);
  localparam int INDEX  = $clog2(LINES);
  localparam int TAG    = ADDR_WIDTH - INDEX - OFFSET;
  localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOOKUP     = 2'd1,
    FILL       = 2'd2,
    WRITE_THRU = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  is_write_r;
  logic                  hit_r;
  logic [LINES-1:0]      valid_r;
  logic [TAG-1:0]        tag_r  [LINES];
  logic [LINE_W-1:0]     data_r [LINES];

  logic [DATA_WIDTH-1:0] cpu_rdata_r;
  logic                  cpu_ready_r;
  logic                  cpu_hit_r;
  logic [ADDR_WIDTH-1:0] l2_addr_r;
  logic [LINE_W-1:0]     l2_data_out_r;
  logic                  l2_read_r;
  logic                  l2_write_r;
  logic [15:0]           hit_count_r;
  logic [15:0]           miss_count_r;

  logic [OFFSET-1:0]     off_s;
  logic [INDEX-1:0]      idx_s;
  logic [TAG-1:0]        tag_s;
  logic [ADDR_WIDTH-1:0] blk_addr_s;
  logic [LINE_W-1:0]     cur_line_s;
  logic                  lookup_hit_s;
  logic                  fill_done_s;
  logic                  arr_we_s;
  logic [LINE_W-1:0]     arr_line_s;

  function automatic logic [DATA_WIDTH-1:0] get_word(input logic [LINE_W-1:0] line,
                                                     input logic [OFFSET-1:0] off);
    return line[int'(off)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0]     line,
                                                   input logic [OFFSET-1:0]     off,
                                                   input logic [DATA_WIDTH-1:0] word);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[int'(off)*DATA_WIDTH +: DATA_WIDTH] = word;
    return merged;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Address split, hit detection and the line image to be installed this cycle
  always_comb begin
    off_s        = addr_r[OFFSET-1:0];
    idx_s        = addr_r[OFFSET +: INDEX];
    tag_s        = addr_r[ADDR_WIDTH-1 -: TAG];
    blk_addr_s   = {addr_r[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
    cur_line_s   = data_r[idx_s];
    lookup_hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    fill_done_s  = bus.l2_ready && bus.l2_block_valid;
    arr_we_s     = 1'b0;
    arr_line_s   = cur_line_s;
    case (state_r)
      LOOKUP: begin
        if (is_write_r && lookup_hit_s) begin
          arr_we_s   = 1'b1;
          arr_line_s = merge_word(cur_line_s, off_s, wdata_r);
        end else begin
          arr_we_s   = 1'b0;
        end
      end
      FILL: begin
        if (fill_done_s) begin
          arr_we_s = 1'b1;
          if (is_write_r) begin
            arr_line_s = merge_word(bus.l2_block_data_in, off_s, wdata_r);
          end else begin
            arr_line_s = bus.l2_block_data_in;
          end
        end else begin
          arr_we_s = 1'b0;
        end
      end
      default: arr_we_s = 1'b0;
    endcase
  end

  // Tag and data arrays keep their contents across reset; only valid bits are cleared
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= arr_line_s;
    end
  end

  // Controller FSM with registered CPU/L2 outputs and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {DATA_WIDTH{1'b0}};
      is_write_r    <= 1'b0;
      hit_r         <= 1'b0;
      valid_r       <= {LINES{1'b0}};
      cpu_rdata_r   <= {DATA_WIDTH{1'b0}};
      cpu_ready_r   <= 1'b0;
      cpu_hit_r     <= 1'b0;
      l2_addr_r     <= {ADDR_WIDTH{1'b0}};
      l2_data_out_r <= {LINE_W{1'b0}};
      l2_read_r     <= 1'b0;
      l2_write_r    <= 1'b0;
      hit_count_r   <= 16'd0;
      miss_count_r  <= 16'd0;
    end else begin
      cpu_ready_r <= 1'b0;
      cpu_hit_r   <= 1'b0;
      cpu_rdata_r <= {DATA_WIDTH{1'b0}};
      case (state_r)
        IDLE: begin
          // A simultaneous read and write is served as a read
          if (bus.cpu_read || bus.cpu_write) begin
            addr_r     <= bus.cpu_addr;
            wdata_r    <= bus.cpu_wdata;
            is_write_r <= !bus.cpu_read;
            state_r    <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_r <= lookup_hit_s;
          if (lookup_hit_s) begin
            hit_count_r <= sat_inc(hit_count_r);
            if (is_write_r) begin
              l2_write_r    <= 1'b1;
              l2_addr_r     <= blk_addr_s;
              l2_data_out_r <= arr_line_s;
              state_r       <= WRITE_THRU;
            end else begin
              cpu_ready_r <= 1'b1;
              cpu_hit_r   <= 1'b1;
              cpu_rdata_r <= get_word(cur_line_s, off_s);
              state_r     <= IDLE;
            end
          end else begin
            miss_count_r <= sat_inc(miss_count_r);
            l2_read_r    <= 1'b1;
            l2_addr_r    <= blk_addr_s;
            state_r      <= FILL;
          end
        end
        FILL: begin
          if (fill_done_s) begin
            valid_r[idx_s] <= 1'b1;
            l2_read_r      <= 1'b0;
            if (is_write_r) begin
              l2_write_r    <= 1'b1;
              l2_data_out_r <= arr_line_s;
              state_r       <= WRITE_THRU;
            end else begin
              cpu_ready_r <= 1'b1;
              cpu_rdata_r <= get_word(bus.l2_block_data_in, off_s);
              state_r     <= IDLE;
            end
          end
        end
        WRITE_THRU: begin
          if (bus.l2_ready) begin
            l2_write_r  <= 1'b0;
            cpu_ready_r <= 1'b1;
            cpu_hit_r   <= hit_r;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.cpu_ready   = cpu_ready_r;
  assign bus.cpu_hit     = cpu_hit_r;
  assign bus.l2_addr     = l2_addr_r;
  assign bus.l2_data_out = l2_data_out_r;
  assign bus.l2_read     = l2_read_r;
  assign bus.l2_write    = l2_write_r;
  assign bus.hit_count   = hit_count_r;
  assign bus.miss_count  = miss_count_r;
endmodule
